// File: rtl/store_buffer_pkg.sv
// Shared constants for the posted-write store buffer: default geometry and
// the word-offset used when comparing word-aligned addresses.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;   // FIFO entries, power of two, >= 2
    localparam int SB_AW    = 32;  // address width
    localparam int SB_DW    = 32;  // data width
    localparam int WORD_OFS = 2;   // byte-offset bits ignored by address compare

endpackage

// File: rtl/store_buffer_if.sv
// Memory-side bus of the store buffer: a back-pressured write port and an
// asynchronous read port. The buffer is the master; data memory is the slave.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_we, mem_waddr, mem_wdata, mem_raddr,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_we, mem_waddr, mem_wdata, mem_raddr,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/store_buffer_sb_forward.sv
// Youngest-match store-to-load forwarding search over the buffered stores.
// Entries are visited from the oldest slot position (tail) to the youngest
// (tail-1); a later hit overrides an earlier one, so the youngest match wins.
module sb_forward
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]    valid,
    input  logic [AW-1:WORD_OFS] entry_addr [DEPTH],
    input  logic [DW-1:0]       entry_data [DEPTH],
    input  logic [PW-1:0]       tail,
    input  logic [AW-1:WORD_OFS] ALUReal,
    output logic                hit,
    output logic [DW-1:0]       data
);

    // Priority scan, oldest to youngest, last matching entry wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] idx;
            idx = tail + PW'(k);
            if (valid[idx] && (entry_addr[idx] == ALUReal)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between a single-cycle core and data memory.
// Stores are accepted in one cycle into a DEPTH-entry FIFO and drained in
// program order to a back-pressured memory write port. Loads see the youngest
// buffered store to the same word, falling back to memory read data.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] ALUReal,
    input  logic [DW-1:0] WriteData,
    output logic [DW-1:0] ReadData,
    output logic          Stall,
    output logic          Empty,
    store_buffer_if.master mem
);

    localparam int            PW         = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   COUNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    logic [AW-1:0]        addr_q [DEPTH];
    logic [DW-1:0]        data_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [PW-1:0]        head_q;
    logic [PW-1:0]        tail_q;
    logic [PW:0]          count_q;

    logic                 drain;
    logic                 enq;
    logic                 full;
    logic [AW-1:WORD_OFS] word_addr [DEPTH];
    logic                 fwd_hit;
    logic [DW-1:0]        fwd_data;

    // Memory write port always presents the head entry while anything is pending.
    assign mem.mem_we    = (count_q != '0);
    assign mem.mem_waddr = addr_q[head_q];
    assign mem.mem_wdata = data_q[head_q];
    assign mem.mem_raddr = ALUReal;

    // A full buffer still accepts a store in the cycle its head drains.
    assign drain = mem.mem_we & mem.mem_ready;
    assign full  = (count_q == FULL_COUNT);
    assign Stall = MemWrite & full & ~drain;
    assign enq   = MemWrite & ~Stall;
    assign Empty = (count_q == '0);

    assign ReadData = fwd_hit ? fwd_data : mem.mem_rdata;

    // Word-granular view of the stored addresses for the forwarding compare.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            word_addr[i] = addr_q[i][AW-1:WORD_OFS];
        end
    end

    sb_forward #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_forward (
        .valid      (valid_q),
        .entry_addr (word_addr),
        .entry_data (data_q),
        .tail       (tail_q),
        .ALUReal    (ALUReal[AW-1:WORD_OFS]),
        .hit        (fwd_hit),
        .data       (fwd_data)
    );

    // Entry payload capture at the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: the payload array has no reset; valid bits and count alone
        // decide whether a slot is meaningful, so stale payload is harmless.
        if (enq) begin
            addr_q[tail_q] <= ALUReal;
            data_q[tail_q] <= WriteData;
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every update here sees
        // the pre-edge state regardless of statement order.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            // Clear first so a full-buffer enqueue into the freed head slot wins.
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_ONE;
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_ONE;
            end
            case ({enq, drain})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks for store_buffer. A word-addressed memory
// array answers the DUT's write/read ports; the random phase compares loads and
// final memory contents against an architectural memory updated in program order.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUReal;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem     [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256];
    logic [31:0] wlog [$];
    logic        rdata_force = 1'b0;
    logic [31:0] rdata_val   = 32'h0;

    store_buffer_if #(.AW(32), .DW(32)) sb_bus ();

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUReal   (ALUReal),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Empty     (Empty),
        .mem       (sb_bus.master)
    );

    always #5 clk = ~clk;

    assign sb_bus.mem_rdata = rdata_force ? rdata_val : mem[sb_bus.mem_raddr[9:2]];

    // Memory model: commit a write whenever the port handshakes, and log its address.
    always @(posedge clk) begin
        if (sb_bus.mem_we && sb_bus.mem_ready) begin
            mem[sb_bus.mem_waddr[9:2]] <= sb_bus.mem_wdata;
            wlog.push_back(sb_bus.mem_waddr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ALUReal   = a;
        WriteData = d;
        #1;
    endtask

    task automatic idle();
        MemWrite = 1'b0;
        #1;
    endtask

    task automatic drain_all(input string tag);
        MemWrite = 1'b0;
        sb_bus.mem_ready = 1'b1;
        for (int i = 0; i < 50 && !Empty; i++) tick();
        check(tag, 32'(Empty), 32'h1);
    endtask

    task automatic check_log(input string tag, input logic [31:0] exp [$]);
        check({tag, "_count"}, 32'(wlog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check(tag, (wlog.size() > i) ? wlog[i] : 32'hFFFF_FFFF, exp[i]);
    endtask

    initial begin
        logic        pend;
        logic [31:0] pa;
        logic [31:0] pd;
        logic [31:0] la;
        int unsigned r;

        reset = 1'b1;
        MemWrite = 1'b0;
        ALUReal = 32'h0;
        WriteData = 32'h0;
        sb_bus.mem_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_mem_we", 32'(sb_bus.mem_we), 32'h0);
        check("rst_empty", 32'(Empty), 32'h1);
        check("rst_stall", 32'(Stall), 32'h0);
        reset = 1'b0;

        // 1: single store, one-cycle latency to memory
        sb_bus.mem_ready = 1'b1;
        store(32'h40, 32'hDEAD_BEEF);
        check("t1_stall", 32'(Stall), 32'h0);
        check("t1_no_bypass", 32'(sb_bus.mem_we), 32'h0);
        tick();
        idle();
        check("t1_mem_we", 32'(sb_bus.mem_we), 32'h1);
        check("t1_waddr", sb_bus.mem_waddr, 32'h40);
        check("t1_wdata", sb_bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("t1_empty", 32'(Empty), 32'h1);
        check("t1_mem", mem[8'h10], 32'hDEAD_BEEF);

        // 2: fill under back-pressure, stall on fifth, release
        wlog.delete();
        sb_bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'(i * 4), 32'h100 + 32'(i));
            check("t2_fill_stall", 32'(Stall), 32'h0);
            tick();
        end
        idle();
        check("t2_head_addr", sb_bus.mem_waddr, 32'h0);
        store(32'h10, 32'h104);
        check("t2_full_stall", 32'(Stall), 32'h1);
        tick();
        check("t2_still_stall", 32'(Stall), 32'h1);
        sb_bus.mem_ready = 1'b1;
        #1;
        check("t2_release", 32'(Stall), 32'h0);
        tick();
        drain_all("t2_drained");
        check_log("t2_order", '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10});

        // 3: youngest-match forwarding
        sb_bus.mem_ready = 1'b0;
        store(32'h20, 32'h1);
        tick();
        store(32'h20, 32'h2);
        tick();
        idle();
        rdata_force = 1'b1;
        rdata_val = 32'h99;
        ALUReal = 32'h20;
        #1;
        check("t3_fwd_young", ReadData, 32'h2);
        ALUReal = 32'h24;
        #1;
        check("t3_miss", ReadData, 32'h99);
        ALUReal = 32'h22;
        #1;
        check("t3_word_cmp", ReadData, 32'h2);
        ALUReal = 32'h20;
        sb_bus.mem_ready = 1'b1;
        #1;
        check("t3_fwd_drain2", ReadData, 32'h2);
        tick();
        check("t3_fwd_draining", ReadData, 32'h2);
        tick();
        rdata_force = 1'b0;
        #1;
        check("t3_empty", 32'(Empty), 32'h1);
        check("t3_mem_read", ReadData, 32'h2);

        // 4: full buffer, simultaneous store and drain, pointer wrap
        wlog.delete();
        sb_bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'h80 + 32'(i * 4), 32'hA0 + 32'(i));
            tick();
        end
        sb_bus.mem_ready = 1'b1;
        store(32'h90, 32'hA4);
        check("t4_enq_deq_stall", 32'(Stall), 32'h0);
        tick();
        sb_bus.mem_ready = 1'b0;
        idle();
        check("t4_head_adv", sb_bus.mem_waddr, 32'h84);
        ALUReal = 32'h90;
        #1;
        check("t4_fwd_wrapped", ReadData, 32'hA4);
        ALUReal = 32'h80;
        #1;
        check("t4_drained_read", ReadData, 32'hA0);
        store(32'h94, 32'hA5);
        check("t4_still_full", 32'(Stall), 32'h1);
        drain_all("t4_drained");
        check_log("t4_order", '{32'h80, 32'h84, 32'h88, 32'h8C, 32'h90});

        // 5: reset discards buffered stores
        sb_bus.mem_ready = 1'b0;
        store(32'hA0, 32'h5A0);
        tick();
        store(32'hA4, 32'h5A4);
        tick();
        store(32'hA8, 32'h5A8);
        tick();
        idle();
        wlog.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t5_mem_we", 32'(sb_bus.mem_we), 32'h0);
        check("t5_empty", 32'(Empty), 32'h1);
        sb_bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_writes", 32'(wlog.size()), 32'h0);
        check("t5_mem_a4", mem[8'h29], 32'h0);

        // 6: random store/load mix against architectural memory
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        pend = 1'b0;
        pa = 32'h0;
        pd = 32'h0;
        for (int c = 0; c < 600; c++) begin
            sb_bus.mem_ready = ($urandom_range(0, 2) == 0);
            if (!pend) begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    pend = 1'b1;
                    pa = 32'h100 + ($urandom_range(0, 7) << 2);
                    pd = $urandom;
                end
            end else begin
                r = 0;
            end
            if (pend) begin
                store(pa, pd);
                if (!Stall) begin
                    ref_mem[pa[9:2]] = pd;
                    pend = 1'b0;
                end
            end else if (r < 8) begin
                MemWrite = 1'b0;
                la = 32'h100 + ($urandom_range(0, 7) << 2);
                ALUReal = la;
                #1;
                check("t6_load", ReadData, ref_mem[la[9:2]]);
            end else begin
                idle();
            end
            tick();
        end
        drain_all("t6_drained");
        for (int i = 0; i < 8; i++)
            check("t6_final_mem", mem[8'h40 + 8'(i)], ref_mem[8'h40 + 8'(i)]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
